// File: rtl/usrt_pkg.sv
// Shared definitions for the synchronous serial transmitter: parity
// encodings, frame state machine states and the parity helper.
package usrt_pkg;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Data is zero-extended to 9 bits so any frame width 5..9 fits.
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

  function automatic logic uses_parity(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/usrt_fifo.sv
// Transmit FIFO: power-of-two depth, wrapping pointers, registered
// occupancy with full/empty flags registered alongside it.
module usrt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     pClk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  import usrt_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_r;
  logic [AW:0]      level_n;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign level   = level_r;

  // Next occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_n = level_r;
    case ({do_push, do_pop})
      2'b10:   level_n = level_r + (AW+1)'(1);
      2'b01:   level_n = level_r - (AW+1)'(1);
      default: level_n = level_r;
    endcase
  end

  // Storage array write; contents need no reset since occupancy guards reads.
  always_ff @(posedge pClk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and flags; pointers wrap naturally at DEPTH.
  always_ff @(posedge pClk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level_r <= level_n;
      full    <= (level_n == FULL_LVL);
      empty   <= (level_n == '0);
    end
  end

endmodule

// File: rtl/usrt_tx.sv
// Synchronous serial transmitter: FIFO-buffered words are framed as
// start / data (LSB first) / optional parity / one or two stop bits,
// with a companion clock uClk low in the first half of every bit.
module usrt_tx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8
) (
  input  logic                          pClk,
  input  logic                          rst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [DIV_W-1:0]              div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic                          tx_en,
  output logic                          txd,
  output logic                          uClk,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  import usrt_pkg::*;

  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              launch;
  logic              cnt_wrap;
  logic [DATA_W-1:0] fifo_rdata;

  tx_state_e         state_r, state_n;
  logic [DIV_W-1:0]  cnt_r, cnt_n;
  logic [DIV_W-1:0]  div_r, div_n;
  logic              phase_r, phase_n;
  logic [3:0]        bit_idx_r, bit_idx_n;
  logic [DATA_W-1:0] shift_r, shift_n;
  logic              par_r, par_n;
  logic              has_par_r, has_par_n;
  logic              two_stop_r, two_stop_n;
  logic              txd_r, txd_n;
  logic              uclk_r, uclk_n;
  logic              busy_r, busy_n;

  usrt_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .pClk  (pClk),
    .rst   (rst),
    .push  (wr_valid),
    .pop   (pop),
    .wdata (wr_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign wr_ready = !fifo_full;
  assign txd      = txd_r;
  assign uClk     = uclk_r;
  assign busy     = busy_r;

  // Frame sequencing: half-bit counter, bit boundaries and the pop/launch of the next word.
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    div_n      = div_r;
    phase_n    = phase_r;
    bit_idx_n  = bit_idx_r;
    shift_n    = shift_r;
    par_n      = par_r;
    has_par_n  = has_par_r;
    two_stop_n = two_stop_r;
    txd_n      = txd_r;
    uclk_n     = uclk_r;
    busy_n     = busy_r;
    launch     = 1'b0;
    pop        = 1'b0;
    cnt_wrap   = (cnt_r == div_r);

    case (state_r)
      ST_IDLE: begin
        txd_n   = 1'b1;
        uclk_n  = 1'b1;
        busy_n  = 1'b0;
        cnt_n   = '0;
        phase_n = 1'b0;
        if (tx_en && !fifo_empty) begin
          launch = 1'b1;
        end else begin
          launch = 1'b0;
        end
      end
      ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
        if (!cnt_wrap) begin
          cnt_n = cnt_r + DIV_W'(1);
        end else if (!phase_r) begin
          // Mid-bit: uClk rises, txd holds.
          cnt_n   = '0;
          phase_n = 1'b1;
          uclk_n  = 1'b1;
        end else begin
          // Bit boundary: the only place txd and state may change.
          cnt_n   = '0;
          phase_n = 1'b0;
          uclk_n  = 1'b0;
          case (state_r)
            ST_START: begin
              state_n   = ST_DATA;
              txd_n     = shift_r[0];
              bit_idx_n = 4'd0;
            end
            ST_DATA: begin
              if (bit_idx_r == 4'(DATA_W-1)) begin
                bit_idx_n = 4'd0;
                if (has_par_r) begin
                  state_n = ST_PARITY;
                  txd_n   = par_r;
                end else begin
                  state_n = ST_STOP;
                  txd_n   = 1'b1;
                end
              end else begin
                bit_idx_n = bit_idx_r + 4'd1;
                shift_n   = shift_r >> 1;
                txd_n     = shift_r[1];
              end
            end
            ST_PARITY: begin
              state_n   = ST_STOP;
              txd_n     = 1'b1;
              bit_idx_n = 4'd0;
            end
            ST_STOP: begin
              if (two_stop_r && (bit_idx_r == 4'd0)) begin
                bit_idx_n = 4'd1;
                txd_n     = 1'b1;
              end else begin
                // End of frame; a ready word launches right here, no idle bit.
                state_n = ST_IDLE;
                txd_n   = 1'b1;
                uclk_n  = 1'b1;
                busy_n  = 1'b0;
                launch  = tx_en && !fifo_empty;
              end
            end
            default: begin
              state_n = ST_IDLE;
              txd_n   = 1'b1;
              uclk_n  = 1'b1;
              busy_n  = 1'b0;
            end
          endcase
        end
      end
      default: begin
        state_n = ST_IDLE;
        txd_n   = 1'b1;
        uclk_n  = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    if (launch) begin
      pop        = 1'b1;
      state_n    = ST_START;
      shift_n    = fifo_rdata;
      par_n      = parity_bit(9'(fifo_rdata), parity_mode);
      has_par_n  = uses_parity(parity_mode);
      two_stop_n = two_stop;
      div_n      = div;
      cnt_n      = '0;
      phase_n    = 1'b0;
      bit_idx_n  = 4'd0;
      txd_n      = 1'b0;
      uclk_n     = 1'b0;
      busy_n     = 1'b1;
    end else begin
      pop = 1'b0;
    end
  end

  // State and registered outputs; synchronous reset aborts any frame.
  always_ff @(posedge pClk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      div_r      <= '0;
      phase_r    <= 1'b0;
      bit_idx_r  <= 4'd0;
      shift_r    <= '0;
      par_r      <= 1'b0;
      has_par_r  <= 1'b0;
      two_stop_r <= 1'b0;
      txd_r      <= 1'b1;
      uclk_r     <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      div_r      <= div_n;
      phase_r    <= phase_n;
      bit_idx_r  <= bit_idx_n;
      shift_r    <= shift_n;
      par_r      <= par_n;
      has_par_r  <= has_par_n;
      two_stop_r <= two_stop_n;
      txd_r      <= txd_n;
      uclk_r     <= uclk_n;
      busy_r     <= busy_n;
    end
  end

endmodule

// File: tb/tb_usrt_tx.sv
// Self-checking bench for usrt_tx: expected serial bits (value and half
// period) are queued when words are pushed and compared at each uClk rise.
module tb_usrt_tx;

  logic       pClk;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic [7:0] div;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       tx_en;
  logic       txd;
  logic       uClk;
  logic       busy;
  logic [2:0] level;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  typedef struct {
    logic b;
    int   half;
  } exp_bit_t;

  exp_bit_t exp_q[$];

  logic prev_uclk = 1'b1;
  bit   have_rise = 1'b0;
  int   last_rise = 0;
  int   last_half = 0;

  usrt_tx #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .DIV_W      (8)
  ) dut (
    .pClk        (pClk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .div         (div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx_en       (tx_en),
    .txd         (txd),
    .uClk        (uClk),
    .busy        (busy),
    .level       (level)
  );

  initial begin
    pClk = 1'b0;
    forever #5 pClk = ~pClk;
  end

  initial begin
    forever begin
      @(posedge pClk);
      cyc = cyc + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fails = n_fails + 1;
      $display("FAIL %s: observed %0d required %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected frame: start, 8 data bits LSB first, optional parity, stop bit(s).
  task automatic add_frame(input logic [7:0] d, input int half, input logic [1:0] pm, input logic ts);
    exp_bit_t e;
    e.half = half;
    e.b = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e.b = d[i];
      exp_q.push_back(e);
    end
    if (pm == 2'b01) begin
      e.b = ^d;
      exp_q.push_back(e);
    end else if (pm == 2'b10) begin
      e.b = ~^d;
      exp_q.push_back(e);
    end
    e.b = 1'b1;
    exp_q.push_back(e);
    if (ts) begin
      exp_q.push_back(e);
    end
  endtask

  // One-cycle push offer; acc is whether the FIFO must accept it.
  task automatic push_word(input logic [7:0] d, input int half, input logic [1:0] pm,
                           input logic ts, input bit acc, input bit score);
    @(negedge pClk);
    check_eq("wr_ready_on_push", 32'(wr_ready), 32'(acc));
    wr_data  = d;
    wr_valid = 1'b1;
    if (acc && score) begin
      add_frame(d, half, pm, ts);
    end
    @(negedge pClk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (busy !== 1'b1 && n < 200) begin
      @(negedge pClk);
      n++;
    end
    check_eq("busy_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 20000) begin
      @(negedge pClk);
      n++;
    end
    check_eq("drain_pending_bits", 32'(exp_q.size()), 32'd0);
    check_eq("drain_busy", 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: at each uClk rise inside a frame, compare txd and bit spacing.
  initial begin
    exp_bit_t e;
    forever begin
      @(negedge pClk);
      if (busy !== 1'b1) begin
        have_rise = 1'b0;
      end else if (uClk === 1'b1 && prev_uclk === 1'b0) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_bit", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("txd_bit", 32'(txd), 32'(e.b));
          if (have_rise) begin
            check_eq("bit_spacing", 32'(cyc - last_rise), 32'(last_half + e.half));
          end
          last_rise = cyc;
          last_half = e.half;
          have_rise = 1'b1;
        end
      end
      prev_uclk = uClk;
    end
  end

  initial begin
    int cnt;
    rst         = 1'b1;
    wr_valid    = 1'b0;
    wr_data     = 8'h00;
    div         = 8'd1;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    tx_en       = 1'b0;
    repeat (3) @(negedge pClk);
    check_eq("rst_txd", 32'(txd), 32'd1);
    check_eq("rst_uclk", 32'(uClk), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_level", 32'(level), 32'd0);
    rst   = 1'b0;
    tx_en = 1'b1;

    // 0xA5, div=1: start bit two cycles after the push cycle.
    push_word(8'hA5, 2, 2'b00, 1'b0, 1'b1, 1'b1);
    check_eq("lat_n1_txd", 32'(txd), 32'd1);
    check_eq("lat_n1_busy", 32'(busy), 32'd0);
    check_eq("lat_n1_level", 32'(level), 32'd1);
    @(negedge pClk);
    check_eq("lat_n2_txd", 32'(txd), 32'd0);
    check_eq("lat_n2_busy", 32'(busy), 32'd1);
    check_eq("lat_n2_uclk", 32'(uClk), 32'd0);
    check_eq("lat_n2_level", 32'(level), 32'd0);
    wait_idle();

    // 0x07 with even then odd parity, two stop bits.
    parity_mode = 2'b01;
    two_stop    = 1'b1;
    push_word(8'h07, 2, 2'b01, 1'b1, 1'b1, 1'b1);
    wait_idle();
    parity_mode = 2'b10;
    push_word(8'h07, 2, 2'b10, 1'b1, 1'b1, 1'b1);
    wait_idle();
    two_stop = 1'b0;

    // Divisor extremes; mode 11 behaves as no parity.
    parity_mode = 2'b00;
    div         = 8'd0;
    push_word(8'h3C, 1, 2'b00, 1'b0, 1'b1, 1'b1);
    wait_idle();
    div         = 8'hFF;
    parity_mode = 2'b11;
    push_word(8'h96, 256, 2'b11, 1'b0, 1'b1, 1'b1);
    wait_idle();
    div         = 8'd1;
    parity_mode = 2'b00;

    // Fill with transmit held off, reject a 5th word, then drain back-to-back.
    tx_en = 1'b0;
    push_word(8'h11, 2, 2'b00, 1'b0, 1'b1, 1'b1);
    push_word(8'h22, 2, 2'b00, 1'b0, 1'b1, 1'b1);
    push_word(8'h33, 2, 2'b00, 1'b0, 1'b1, 1'b1);
    push_word(8'h44, 2, 2'b00, 1'b0, 1'b1, 1'b1);
    check_eq("full_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("full_level", 32'(level), 32'd4);
    push_word(8'h55, 2, 2'b00, 1'b0, 1'b0, 1'b1);
    check_eq("reject_level", 32'(level), 32'd4);
    check_eq("held_busy", 32'(busy), 32'd0);
    @(negedge pClk);
    tx_en = 1'b1;
    wait_busy();
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge pClk);
    end
    check_eq("b2b_busy_cycles", 32'(cnt), 32'd160);
    wait_idle();

    // tx_en dropped during frame 1: frame 1 finishes, frame 2 waits.
    push_word(8'hC6, 2, 2'b00, 1'b0, 1'b1, 1'b1);
    push_word(8'h39, 2, 2'b00, 1'b0, 1'b1, 1'b1);
    wait_busy();
    repeat (5) @(negedge pClk);
    tx_en = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge pClk);
    end
    repeat (20) @(negedge pClk);
    check_eq("hold_busy", 32'(busy), 32'd0);
    check_eq("hold_level", 32'(level), 32'd1);
    check_eq("hold_frame1_done", 32'(exp_q.size()), 32'd10);
    tx_en = 1'b1;
    @(negedge pClk);
    check_eq("resume_busy", 32'(busy), 32'd1);
    check_eq("resume_level", 32'(level), 32'd0);
    wait_idle();

    // div changed mid-frame: current frame keeps 4-cycle bits, next uses 8.
    push_word(8'h5A, 2, 2'b00, 1'b0, 1'b1, 1'b1);
    push_word(8'hC3, 4, 2'b00, 1'b0, 1'b1, 1'b1);
    repeat (6) @(negedge pClk);
    div = 8'd3;
    wait_idle();
    div = 8'd1;

    // Reset in the first half of data bit 3 with another word queued.
    push_word(8'h5A, 2, 2'b00, 1'b0, 1'b1, 1'b1);
    wait_busy();
    push_word(8'hE7, 2, 2'b00, 1'b0, 1'b1, 1'b0);
    repeat (15) @(negedge pClk);
    check_eq("pre_rst_txd_bit3", 32'(txd), 32'd1);
    check_eq("pre_rst_uclk", 32'(uClk), 32'd0);
    check_eq("pre_rst_level", 32'(level), 32'd1);
    rst = 1'b1;
    @(negedge pClk);
    rst = 1'b0;
    exp_q.delete();
    check_eq("mid_rst_txd", 32'(txd), 32'd1);
    check_eq("mid_rst_uclk", 32'(uClk), 32'd1);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_level", 32'(level), 32'd0);
    check_eq("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
    repeat (3) @(negedge pClk);
    check_eq("post_rst_idle", 32'(busy), 32'd0);

    // Recovery after reset.
    push_word(8'h81, 2, 2'b00, 1'b0, 1'b1, 1'b1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/usrt_tx.md
USRT_TX -- requirements
Module: usrt_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries (power of 2, >=2).
REQ-003 The block SHALL have parameter DIV_W, default 8, meaning width of the baud divisor input.
REQ-004 pClk  in  1  system clock; all logic rising-edge pClk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wr_valid  in  1  host offers a word.
REQ-007 wr_ready  out  1  FIFO can accept a word.
REQ-008 wr_data  in  DATA_W  word to transmit.
REQ-009 div  in  DIV_W  half bit period minus 1, in pClk cycles.
REQ-010 parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-011 two_stop  in  1  1 = two stop bits, 0 = one.
REQ-012 tx_en  in  1  permits starting a new frame.
REQ-013 txd  out  1  serial data, LSB first.
REQ-014 uClk  out  1  synchronous serial clock, driven only during frames.
REQ-015 busy  out  1  frame in progress.
REQ-016 level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Push SHALL occur on a cycle with wr_valid && wr_ready; wr_ready = !full, registered from occupancy; no same-cycle bypass into the shifter.
REQ-018 Push and pop in the same cycle SHALL leave level unchanged; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; transitions occur only at bit boundaries.
REQ-020 In IDLE with tx_en=1 and level>0, the block SHALL pop one word and latch wr word, parity_mode, two_stop and div, then enter START next cycle.
REQ-021 Bit period SHALL be 2*(div_latched+1) pClk cycles; uClk low for the first half and high for the second half of every bit; txd changes only at bit start.
REQ-022 START SHALL drive txd=0 for one bit; DATA SHALL drive DATA_W bits LSB first; PARITY (skipped when mode none) SHALL drive XOR of data bits for even, its inverse for odd; STOP SHALL drive txd=1 for 1 or 2 bits.
REQ-023 After the last stop bit the FSM SHALL return to IDLE; if the pop condition holds that same cycle the next frame's pop SHALL occur there, giving back-to-back frames with no idle bit.
REQ-024 In IDLE txd=1, uClk=1, busy=0; busy=1 in every other state.
REQ-025 Latency: word pushed at cycle N into an empty FIFO with FSM idle and tx_en=1 SHALL pop at N+1 and start bit SHALL appear on txd at N+2.
REQ-026 Deasserting tx_en mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-027 Changes on div/parity_mode/two_stop mid-frame SHALL have no effect until the next pop.
REQ-028 div=0 SHALL give a 2-cycle bit period; div=all-ones SHALL not overflow the counter.

Reset
REQ-029 With rst=1 at a pClk edge, the block SHALL flush the FIFO, abort any frame and enter IDLE.
REQ-030 Reset values: txd=1, uClk=1, busy=0, wr_ready=1, level=0; bit and baud counters 0.

Structure
REQ-031 Package usrt_pkg SHALL hold the parity_mode encodings and the FSM state enum.
REQ-032 The FIFO SHALL be a separate sub-module usrt_fifo (parametrised width/depth, push/pop/full/empty/level).

Verification
REQ-033 DATA_W=8, div=1, parity none, one stop, push 0xA5 -> txd 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; start bit at push+2.
REQ-034 Push 0x07, even parity then odd parity -> parity bit 1 then 0; two_stop=1 -> stop held 2 bit periods.
REQ-035 tx_en=0, push 5 words into depth 4 -> wr_ready=0 after 4th push, level=4, 5th word not accepted; tx_en=1 -> 4 back-to-back frames, no idle bit between.
REQ-036 rst pulsed in mid DATA bit 3 -> next cycle txd=1, uClk=1, busy=0, level=0.
REQ-037 tx_en dropped during frame 1 of 2 queued -> frame 1 completes, frame 2 starts only after tx_en returns to 1.
REQ-038 div changed 1->3 mid-frame -> current frame keeps 4-cycle bits, next frame uses 8-cycle bits.
